// File: rtl/msu_pkg.sv
// Shared types for the MSU SD-card sector arbiter.
// State encoding, requester indices and default LBA width.
package msu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        REL  = 2'd3
    } arb_state_t;

    localparam int REQ_AUDIO = 0;
    localparam int REQ_DATA  = 1;

    localparam int LBA_W_DEF = 21;

endpackage

// File: rtl/msu_sd_arbiter.sv
// Two-requester arbiter (audio/data) sharing a single HPS sector-read port.
// Round-robin on contention, LBA latched at grant, ack timeout with sticky flag.
module msu_sd_arbiter
    import msu_pkg::*;
#(
    parameter logic [19:0] ACK_TIMEOUT = 20'd1000000,
    parameter int          LBA_W       = LBA_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_rd,
    input  logic [LBA_W-1:0] a_lba,
    output logic             a_ack,
    output logic             a_buff_wr,
    input  logic             d_rd,
    input  logic [LBA_W-1:0] d_lba,
    output logic             d_ack,
    output logic             d_buff_wr,
    output logic             sd_rd,
    output logic [LBA_W-1:0] sd_lba,
    input  logic             sd_ack,
    input  logic             sd_buff_wr,
    output logic [1:0]       grant,
    output logic             busy,
    output logic             timeout_err
);

    arb_state_t  state;
    logic [19:0] tmo_cnt;
    logic        last_grant;
    logic        pick_data;

    // last_grant: 0 = audio served last, 1 = data served last
    always_comb begin
        pick_data = 1'b0;
        if (a_rd && d_rd)
            pick_data = ~last_grant;
        else if (d_rd)
            pick_data = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sd_rd       <= 1'b0;
            sd_lba      <= '0;
            grant       <= 2'b00;
            timeout_err <= 1'b0;
            tmo_cnt     <= 20'd0;
            last_grant  <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!sd_ack && (a_rd || d_rd)) begin
                        state   <= REQ;
                        sd_rd   <= 1'b1;
                        tmo_cnt <= 20'd0;
                        if (pick_data) begin
                            sd_lba <= d_lba;
                            grant  <= 2'b10;
                        end else begin
                            sd_lba <= a_lba;
                            grant  <= 2'b01;
                        end
                    end
                end
                REQ: begin
                    if (sd_ack) begin
                        state <= XFER;
                        sd_rd <= 1'b0;
                    end else if (tmo_cnt == ACK_TIMEOUT - 20'd1) begin
                        state       <= REL;
                        sd_rd       <= 1'b0;
                        timeout_err <= 1'b1;
                        grant       <= 2'b00;
                        last_grant  <= grant[REQ_DATA];
                    end else begin
                        tmo_cnt <= tmo_cnt + 20'd1;
                    end
                end
                XFER: begin
                    // Grant drops as REL is entered so strobes in REL go nowhere
                    if (!sd_ack) begin
                        state      <= REL;
                        grant      <= 2'b00;
                        last_grant <= grant[REQ_DATA];
                    end
                end
                REL: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign a_ack     = sd_ack & grant[REQ_AUDIO];
    assign d_ack     = sd_ack & grant[REQ_DATA];
    assign a_buff_wr = sd_buff_wr & grant[REQ_AUDIO];
    assign d_buff_wr = sd_buff_wr & grant[REQ_DATA];

endmodule

// File: tb/tb_msu_sd_arbiter.sv
// Directed bench for msu_sd_arbiter with a short ack timeout.
// Each step checks outputs against hand-computed values.
module tb_msu_sd_arbiter;

    localparam int LW = 21;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_rd, d_rd;
    logic [LW-1:0] a_lba, d_lba;
    logic          a_ack, a_buff_wr, d_ack, d_buff_wr;
    logic          sd_rd;
    logic [LW-1:0] sd_lba;
    logic          sd_ack, sd_buff_wr;
    logic [1:0]    grant;
    logic          busy, timeout_err;

    int vectors = 0;
    int miscompares = 0;

    msu_sd_arbiter #(.ACK_TIMEOUT(20'd16), .LBA_W(LW)) dut (
        .clk(clk), .reset(reset),
        .a_rd(a_rd), .a_lba(a_lba), .a_ack(a_ack), .a_buff_wr(a_buff_wr),
        .d_rd(d_rd), .d_lba(d_lba), .d_ack(d_ack), .d_buff_wr(d_buff_wr),
        .sd_rd(sd_rd), .sd_lba(sd_lba), .sd_ack(sd_ack),
        .sd_buff_wr(sd_buff_wr), .grant(grant), .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Wait (bounded) for a grant, report it, then complete one short transfer
    task automatic serve(output logic [1:0] g, output logic [LW-1:0] l);
        for (int k = 0; k < 20; k++) begin
            if (sd_rd) break;
            tick();
        end
        g = sd_rd ? grant : 2'b11;
        l = sd_lba;
        sd_ack = 1'b1;
        tick();
        sd_ack = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        logic [1:0]    g;
        logic [LW-1:0] l;
        int            na, nd, n, bad;

        a_rd = 0; d_rd = 0; a_lba = '0; d_lba = '0;
        sd_ack = 0; sd_buff_wr = 0;
        do_reset();

        chk("rst_sd_rd", sd_rd, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tmo", timeout_err, 0);
        chk("rst_lba", sd_lba, 0);

        // Single audio request, 256-strobe transfer
        a_rd = 1; a_lba = 5;
        tick();
        chk("single_sd_rd", sd_rd, 1);
        chk("single_lba", sd_lba, 5);
        chk("single_grant", grant, 2'b01);
        chk("single_busy", busy, 1);
        a_rd = 0; a_lba = 6;
        sd_ack = 1; sd_buff_wr = 1;
        #1;
        chk("single_a_ack", a_ack, 1);
        chk("single_d_ack", d_ack, 0);
        na = 0; nd = 0;
        for (int i = 0; i < 256; i++) begin
            #1;
            na += int'(a_buff_wr);
            nd += int'(d_buff_wr);
            tick();
        end
        chk("single_sd_rd_low", sd_rd, 0);
        chk("single_lba_hold", sd_lba, 5);
        sd_ack = 0; sd_buff_wr = 0;
        tick();
        chk("rel_grant", grant, 0);
        chk("rel_busy", busy, 1);
        tick();
        chk("idle_busy", busy, 0);
        chk("a_wr_count", na, 256);
        chk("d_wr_count", nd, 0);

        // Stray strobe and ack in IDLE
        sd_buff_wr = 1;
        #1;
        chk("stray_a_wr", a_buff_wr, 0);
        chk("stray_d_wr", d_buff_wr, 0);
        sd_buff_wr = 0;
        a_rd = 1; sd_ack = 1;
        tick();
        chk("ack_blocks_grant", grant, 0);
        chk("ack_blocks_rd", sd_rd, 0);
        a_rd = 0; sd_ack = 0;
        tick();

        // Contention round robin from reset
        do_reset();
        a_rd = 1; d_rd = 1; a_lba = 1; d_lba = 2;
        serve(g, l);
        chk("rr0_grant", g, 2'b01);
        chk("rr0_lba", l, 1);
        chk("rr_gap_grant", grant, 0);
        serve(g, l);
        chk("rr1_grant", g, 2'b10);
        chk("rr1_lba", l, 2);
        serve(g, l);
        chk("rr2_grant", g, 2'b01);
        serve(g, l);
        chk("rr3_grant", g, 2'b10);
        a_rd = 0; d_rd = 0;
        tick();
        tick();

        // LBA change after grant is ignored; dropped rd still completes
        d_rd = 1; d_lba = 7;
        tick();
        chk("lba_grant", grant, 2'b10);
        d_lba = 9;
        tick();
        chk("lba_hold", sd_lba, 7);
        d_rd = 0;
        tick();
        chk("drop_sd_rd", sd_rd, 1);
        sd_ack = 1;
        tick();
        chk("drop_d_ack", d_ack, 1);
        chk("drop_a_ack", a_ack, 0);
        sd_ack = 0;
        tick();
        tick();

        // Ack timeout
        a_rd = 1; a_lba = 3;
        tick();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!sd_rd) break;
            n++;
            tick();
        end
        chk("tmo_cycles", n, 16);
        chk("tmo_flag", timeout_err, 1);
        chk("tmo_grant", grant, 0);
        tick();
        tick();
        chk("tmo_next_rd", sd_rd, 1);
        chk("tmo_next_grant", grant, 2'b01);
        a_rd = 0;
        sd_ack = 1;
        tick();
        sd_ack = 0;
        tick();
        tick();
        chk("tmo_sticky", timeout_err, 1);

        // Reset mid-transfer with ack held high
        d_rd = 1; d_lba = 4;
        tick();
        sd_ack = 1;
        tick();
        reset = 1;
        tick();
        reset = 0;
        chk("mid_rst_tmo", timeout_err, 0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (grant != 0 || d_ack || a_ack || sd_rd) bad++;
            tick();
        end
        chk("mid_rst_no_grant", bad, 0);
        sd_ack = 0;
        tick();
        chk("mid_rst_grant", grant, 2'b10);
        chk("mid_rst_lba", sd_lba, 4);
        d_rd = 0;
        sd_ack = 1;
        tick();
        sd_ack = 0;
        tick();
        tick();
        chk("end_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/msu_sd_arbiter.md
MSU_SD_ARBITER -- requirements
Module: msu_sd_arbiter

Interface
REQ-001 The module SHALL use reset reset, synchronous, active-high, and clock clk.
REQ-002 Parameters SHALL be: ACK_TIMEOUT, default 20'd1000000, the cycles allowed from sd_rd assertion to sd_ack; LBA_W, default 21, the LBA width.
REQ-003 Ports SHALL be, in order:
- clk  in  1  clock.
- reset  in  1  synchronous reset.
- a_rd  in  1  audio sector read request (level).
- a_lba  in  LBA_W  audio sector address.
- a_ack  out  1  audio acknowledge.
- a_buff_wr  out  1  audio buffer write strobe.
- d_rd  in  1  data-track sector read request (level).
- d_lba  in  LBA_W  data sector address.
- d_ack  out  1  data acknowledge.
- d_buff_wr  out  1  data buffer write strobe.
- sd_rd  out  1  HPS read request.
- sd_lba  out  LBA_W  HPS sector address.
- sd_ack  in  1  HPS transfer acknowledge.
- sd_buff_wr  in  1  HPS buffer write strobe.
- grant  out  2  one-hot owner: bit0 audio, bit1 data.
- busy  out  1  high in any state except IDLE.
- timeout_err  out  1  sticky acknowledge-timeout flag.

Function
REQ-004 The FSM SHALL have four states: IDLE, REQ, XFER, REL.
REQ-005 IDLE: when sd_ack=0 and a_rd or d_rd is high, the FSM SHALL select one requester, latch its LBA into sd_lba, set grant, and enter REQ.
REQ-006 If both requests are high, selection SHALL be round-robin against last_grant; last_grant resets to data, so audio wins the first contention.
REQ-007 While in IDLE with sd_ack=1, the FSM SHALL not grant; this covers an ack still high after a mid-transfer reset.
REQ-008 sd_rd SHALL be registered and high for every REQ cycle.
REQ-009 sd_rd SHALL fall on the clock edge at which sd_ack=1 is sampled; the FSM enters XFER on that edge.
REQ-010 sd_lba SHALL hold the latched value from grant until the next grant; requester LBA changes after grant are ignored.
REQ-011 If the granted requester drops its rd during REQ, the transaction SHALL still complete; the FSM does not abort.
REQ-012 a_ack SHALL equal sd_ack & grant[0], and d_ack SHALL equal sd_ack & grant[1] (combinational, zero latency).
REQ-013 a_buff_wr SHALL equal sd_buff_wr & grant[0], and d_buff_wr SHALL equal sd_buff_wr & grant[1].
REQ-014 The non-granted requester SHALL see ack=0 and buff_wr=0 at all times.
REQ-015 XFER: the FSM SHALL remain in XFER while sd_ack=1 and enter REL on the first cycle sd_ack=0.
REQ-016 REL: for exactly one cycle, the FSM SHALL clear grant, update last_grant to the just-served requester, and return to IDLE.
REQ-017 A requester still requesting in IDLE SHALL get its next grant no sooner than 1 cycle after REL.
REQ-018 A 20-bit timeout counter SHALL clear on REQ entry and increment each REQ cycle.
REQ-019 When the timeout counter reaches ACK_TIMEOUT-1 without sd_ack, the FSM SHALL deassert sd_rd, set timeout_err, and enter REL.
REQ-020 timeout_err SHALL stay set until reset.
REQ-021 sd_buff_wr or sd_ack pulses in IDLE or REL SHALL be dropped and routed nowhere.
REQ-022 If a_rd and sd_ack rise on the same cycle in IDLE, REQ-007 SHALL take precedence.

Reset
REQ-023 On reset: state=IDLE, sd_rd=0, sd_lba=0, grant=0, busy=0, timeout_err=0, timeout counter=0, last_grant=data.
REQ-024 Reset SHALL override every state, including mid-XFER; ack and buff_wr outputs go to 0 on the next cycle.

Structure
REQ-025 The state encoding, requester index constants (REQ_AUDIO=0, REQ_DATA=1), and the LBA_W default SHALL reside in package msu_pkg.
REQ-026 The module SHALL be a single module with no sub-module; round-robin selection and the timeout counter are inline.

Verification
REQ-027 Single request: a_rd=1, a_lba=5 -> sd_rd high the next cycle with sd_lba=5; sd_ack held 256 cycles with 256 sd_buff_wr pulses -> 256 a_buff_wr pulses, 0 d_buff_wr pulses.
REQ-028 Contention: a_rd and d_rd high together from reset -> grants in order audio, data, audio, data over four transfers.
REQ-029 LBA change: d_lba changes from 7 to 9 during REQ -> sd_lba stays 7.
REQ-030 Timeout: ACK_TIMEOUT=16, no sd_ack -> sd_rd falls after 16 REQ cycles, timeout_err=1, and the next request is still served.
REQ-031 Reset mid-transfer: reset during XFER with sd_ack staying high 10 more cycles -> no grant until sd_ack=0, then a pending d_rd is granted.
REQ-032 Stray strobe: a stray sd_buff_wr pulse in IDLE -> no a_buff_wr or d_buff_wr pulse.
